// File: rtl/fifo_umbrales_pkg.sv
// Shared constants for the per-lane threshold FIFO: default geometry,
// threshold width and the all-lanes-empty mask used by the control FSM.
package fifo_umbrales_pkg;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int ADDR_WIDTH_DEF = 3;
    localparam int UMBRAL_W       = 3;
    localparam int NUM_LANES      = 10;

    // Every lane's fifo_empty set: what the control FSM compares its empty vector against.
    localparam logic [NUM_LANES-1:0] LANE_MASK_EMPTY = 10'b1111111111;

    // Next occupancy given the accepted read/write of this cycle.
    function automatic logic [ADDR_WIDTH_DEF:0] next_count(
        input logic [ADDR_WIDTH_DEF:0] cnt,
        input logic                    wr,
        input logic                    rd
    );
        logic [ADDR_WIDTH_DEF:0] res;
        res = cnt;
        if (wr && !rd)
            res = cnt + 1'b1;
        else if (rd && !wr)
            res = cnt - 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/fifo_umbrales_mem.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous
// read port. Not reset, so contents survive a FIFO reset (pointers are what
// make them invisible).
module fifo_umbrales_mem #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Write port: capture the word at the write pointer.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_umbrales.sv
// Per-lane transaction FIFO with umbral_alto/umbral_bajo flow-control flags.
// Optional feature: define FIFO_OCCUPANCY_EN to expose the live word count
// on an extra output port "occupancy".
module fifo_umbrales
    import fifo_umbrales_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_enable,
    input  logic [UMBRAL_W-1:0]   umbral_alto,
    input  logic [UMBRAL_W-1:0]   umbral_bajo,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_full,
    output logic                  almost_empty,
`ifdef FIFO_OCCUPANCY_EN
    output logic [ADDR_WIDTH:0]   occupancy,
`endif
    output logic                  error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid;
    logic                  r_error;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_overflow;
    logic                  w_underflow;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic [ADDR_WIDTH:0]   w_alto;
    logic [ADDR_WIDTH:0]   w_bajo;

    // A read never bypasses a same-cycle write, so an empty FIFO rejects it;
    // a full FIFO still takes a write if a read frees a slot on the same edge.
    assign w_rd_acc    = rd_enable & ~fifo_empty;
    assign w_wr_acc    = wr_enable & (~fifo_full | w_rd_acc);
    assign w_overflow  = wr_enable & fifo_full & ~w_rd_acc;
    assign w_underflow = rd_enable & fifo_empty;

    fifo_umbrales_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= next_count(r_count, w_wr_acc, w_rd_acc);
        end
    end

    // Registered read data: loads on an accepted read, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= w_rd_acc;
            if (w_rd_acc)
                r_data_out <= w_rdata;
        end
    end

    // Sticky error: any overflow or underflow, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_error <= 1'b0;
        else if (w_overflow || w_underflow)
            r_error <= 1'b1;
    end

    assign w_alto = (ADDR_WIDTH+1)'(umbral_alto);
    assign w_bajo = (ADDR_WIDTH+1)'(umbral_bajo);

    assign fifo_empty   = (r_count == '0);
    assign fifo_full    = (r_count == (ADDR_WIDTH+1)'(DEPTH));
    // A zero high threshold disables the pause request entirely.
    assign almost_full  = (umbral_alto != '0) && (r_count >= w_alto);
    assign almost_empty = (r_count <= w_bajo);
    assign data_out     = r_data_out;
    assign valid_out    = r_valid;
    assign error        = r_error;
`ifdef FIFO_OCCUPANCY_EN
    assign occupancy    = r_count;
`endif

endmodule

// File: tb/tb_fifo_umbrales.sv
// Directed self-checking bench for fifo_umbrales (DEPTH 8, DATA_WIDTH 6).
module tb_fifo_umbrales;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_enable;
    logic [5:0] data_in;
    logic       rd_enable;
    logic [2:0] umbral_alto;
    logic [2:0] umbral_bajo;
    logic [5:0] data_out;
    logic       valid_out;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_full;
    logic       almost_empty;
    logic       error;
`ifdef FIFO_OCCUPANCY_EN
    logic [3:0] occupancy;
`endif

    int checks = 0;
    int errors = 0;

    fifo_umbrales dut (
        .clk          (clk),
        .reset        (reset),
        .wr_enable    (wr_enable),
        .data_in      (data_in),
        .rd_enable    (rd_enable),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_OCCUPANCY_EN
        .occupancy    (occupancy),
`endif
        .error        (error)
    );

    always #5 clk = ~clk;

    // One clock with the given request; outputs sampled 1ns after the edge.
    task automatic cyc(input logic w, input logic [5:0] d, input logic r);
        wr_enable = w;
        data_in   = d;
        rd_enable = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_enable = 0; rd_enable = 0; data_in = 0;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        umbral_alto = 3'd6; umbral_bajo = 3'd2;
        do_reset();
        checks++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || almost_empty !== 1'b1 ||
            almost_full !== 1'b0 || valid_out !== 1'b0 || error !== 1'b0 || data_out !== 6'h00) begin
            errors++;
            $display("FAIL reset_init: empty=%b full=%b ae=%b af=%b vld=%b err=%b dout=%h required 1 0 1 0 0 0 00",
                     fifo_empty, fifo_full, almost_empty, almost_full, valid_out, error, data_out);
        end
        // Build up state: error set, 5 words, then one read so valid_out=1 and 4 remain.
        cyc(0, 6'h00, 1);
        for (int i = 0; i < 5; i++) cyc(1, 6'(i + 1), 0);
        cyc(0, 6'h00, 1);
        checks++;
        if (error !== 1'b1 || valid_out !== 1'b1 || data_out !== 6'h01) begin
            errors++;
            $display("FAIL reset_prestate: err=%b vld=%b dout=%h required 1 1 01", error, valid_out, data_out);
        end
        // Assert reset away from any edge; it must act immediately.
        wr_enable = 0; rd_enable = 0;
        #2;
        reset = 1;
        #1;
        checks++;
        if (fifo_empty !== 1'b1 || error !== 1'b0 || valid_out !== 1'b0 || data_out !== 6'h00) begin
            errors++;
            $display("FAIL reset_async: empty=%b err=%b vld=%b dout=%h required 1 0 0 00",
                     fifo_empty, error, valid_out, data_out);
        end
`ifdef FIFO_OCCUPANCY_EN
        checks++;
        if (occupancy !== 4'd0) begin
            errors++;
            $display("FAIL reset_occ: occupancy=%0d required 0", occupancy);
        end
`endif
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= 8; i++) cyc(1, 6'(i), 0);
        checks++;
        if (fifo_full !== 1'b1 || fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b empty=%b required 1 0", fifo_full, fifo_empty);
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 6'h00, 1);
            checks++;
            if (data_out !== 6'(i) || valid_out !== 1'b1) begin
                errors++;
                $display("FAIL drain_%0d: dout=%h vld=%b required %h 1", i, data_out, valid_out, 6'(i));
            end
        end
        cyc(0, 6'h00, 0);
        checks++;
        if (fifo_empty !== 1'b1 || valid_out !== 1'b0 || data_out !== 6'h08 || error !== 1'b0) begin
            errors++;
            $display("FAIL drain_end: empty=%b vld=%b dout=%h err=%b required 1 0 08 0",
                     fifo_empty, valid_out, data_out, error);
        end
    endtask

    task automatic test_thresholds();
        umbral_alto = 3'd6; umbral_bajo = 3'd2;
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            cyc(1, 6'(k), 0);
            checks++;
            if (almost_full !== (k >= 6) || almost_empty !== (k <= 2)) begin
                errors++;
                $display("FAIL thr_up_%0d: af=%b ae=%b required %b %b", k, almost_full, almost_empty,
                         (k >= 6), (k <= 2));
            end
        end
        for (int k = 6; k >= 2; k--) begin
            cyc(0, 6'h00, 1);
            checks++;
            if (almost_full !== (k >= 6) || almost_empty !== (k <= 2)) begin
                errors++;
                $display("FAIL thr_dn_%0d: af=%b ae=%b required %b %b", k, almost_full, almost_empty,
                         (k >= 6), (k <= 2));
            end
        end
        // Occupancy 2 now; refill to 7, then a zero high threshold must disable pause.
        for (int k = 0; k < 5; k++) cyc(1, 6'h00, 0);
        umbral_alto = 3'd0;
        #1;
        checks++;
        if (almost_full !== 1'b0) begin
            errors++;
            $display("FAIL thr_alto_zero: af=%b required 0", almost_full);
        end
        umbral_alto = 3'd7;
        #1;
        checks++;
        if (almost_full !== 1'b1) begin
            errors++;
            $display("FAIL thr_alto_seven: af=%b required 1", almost_full);
        end
        umbral_alto = 3'd6;
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 6'(8'h10 + i), 0);
        cyc(1, 6'h3F, 0);
        checks++;
        if (fifo_full !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL overflow: full=%b err=%b required 1 1", fifo_full, error);
        end
`ifdef FIFO_OCCUPANCY_EN
        checks++;
        if (occupancy !== 4'd8) begin
            errors++;
            $display("FAIL overflow_occ: occupancy=%0d required 8", occupancy);
        end
`endif
        for (int i = 0; i < 8; i++) begin
            cyc(0, 6'h00, 1);
            checks++;
            if (data_out !== 6'(8'h10 + i)) begin
                errors++;
                $display("FAIL overflow_drain_%0d: dout=%h required %h", i, data_out, 6'(8'h10 + i));
            end
        end
        checks++;
        if (fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL overflow_dropped: empty=%b required 1", fifo_empty);
        end
        do_reset();
        cyc(0, 6'h00, 1);
        checks++;
        if (error !== 1'b1 || valid_out !== 1'b0 || data_out !== 6'h00 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow: err=%b vld=%b dout=%h empty=%b required 1 0 00 1",
                     error, valid_out, data_out, fifo_empty);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 6'(8'h20 + i), 0);
        cyc(1, 6'h2A, 1);
        checks++;
        if (data_out !== 6'h20 || valid_out !== 1'b1 || fifo_full !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL simul_full: dout=%h vld=%b full=%b err=%b required 20 1 1 0",
                     data_out, valid_out, fifo_full, error);
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 6'h00, 1);
            checks++;
            if (data_out !== ((i == 8) ? 6'h2A : 6'(8'h20 + i))) begin
                errors++;
                $display("FAIL simul_drain_%0d: dout=%h required %h", i, data_out,
                         ((i == 8) ? 6'h2A : 6'(8'h20 + i)));
            end
        end
        do_reset();
        cyc(1, 6'h33, 1);
        checks++;
        if (valid_out !== 1'b0 || fifo_empty !== 1'b0 || data_out !== 6'h00 || error !== 1'b1) begin
            errors++;
            $display("FAIL simul_empty: vld=%b empty=%b dout=%h err=%b required 0 0 00 1",
                     valid_out, fifo_empty, data_out, error);
        end
`ifdef FIFO_OCCUPANCY_EN
        checks++;
        if (occupancy !== 4'd1) begin
            errors++;
            $display("FAIL simul_empty_occ: occupancy=%0d required 1", occupancy);
        end
`endif
        cyc(0, 6'h00, 1);
        checks++;
        if (data_out !== 6'h33 || valid_out !== 1'b1 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL simul_empty_read: dout=%h vld=%b empty=%b required 33 1 1",
                     data_out, valid_out, fifo_empty);
        end
    endtask

    task automatic test_wrap();
        umbral_alto = 3'd6; umbral_bajo = 3'd2;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 6'(i), 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 6'(i + 3), 1);
            checks++;
            if (data_out !== 6'(i) || valid_out !== 1'b1 || almost_empty !== 1'b0 ||
                almost_full !== 1'b0 || fifo_empty !== 1'b0) begin
                errors++;
                $display("FAIL wrap_%0d: dout=%h vld=%b ae=%b af=%b empty=%b required %h 1 0 0 0",
                         i, data_out, valid_out, almost_empty, almost_full, fifo_empty, 6'(i));
            end
        end
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL wrap_error: err=%b required 0", error);
        end
    endtask

    initial begin
        reset = 1; wr_enable = 0; rd_enable = 0; data_in = 0;
        umbral_alto = 3'd6; umbral_bajo = 3'd2;
        test_reset();
        test_fill_drain();
        test_thresholds();
        test_overflow_underflow();
        test_simultaneous();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
